folded_majority_seq: RTL and testbench

Sequential, folded threshold/majority evaluator: it accepts an N-bit vector through a valid/ready handshake and counts its ones W bits per cycle. It reports whether the count reaches a programmable threshold. It is the parametrised successor of the fixed-width combinational majority gates (e.g. Maj57), trading latency for area by reusing one W-bit popcount slice. It sits between a vector producer and any consumer of a 1-bit majority/threshold decision.

---
 rtl/folded_majority_seq_if.sv | 35 +++
 rtl/folded_majority_seq.sv | 121 ++++++++++++
 tb/tb_folded_majority_seq.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/folded_majority_seq_if.sv
// folded_majority_seq_if
//   Handshake bundle between a vector producer and the folded majority
//   evaluator, plus the result side towards the consumer.
//   Signals:
//     in_valid  producer -> block   vector valid
//     in_ready  block -> producer   block can accept (IDLE only)
//     in_data   producer -> block   N-bit vector, bit i = xi
//     out_valid block -> consumer   result valid
//     out_ready consumer -> block   result accepted
//     y         block -> consumer   threshold decision
//     count     block -> consumer   ones counted in processed chunks
//   Modports: slave = evaluator side, master = producer/consumer side.
interface folded_majority_seq_if #(
    parameter int N = 57
);
    localparam int CW = $clog2(N + 1);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic          y;
    logic [CW-1:0] count;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, y, count
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, y, count
    );
endinterface

// File: rtl/folded_majority_seq.sv
// folded_majority_seq
//   Folded threshold/majority evaluator. A captured N-bit vector is walked
//   W bits per cycle through one popcount slice; the running count is
//   compared against THRESH to produce y (y=1 iff popcount >= THRESH).
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    folded_majority_seq_if.slave (valid/ready in, valid/ready out,
//            y and count results)
//   Optional feature: define FOLDMAJ_EARLY_EXIT_EN to leave ACCUM as soon
//   as the decision is settled (count already reaches THRESH, or the
//   remaining bits can no longer reach it). count then holds the partial
//   count at the exit point; y is identical in both builds.
module folded_majority_seq #(
    parameter int N      = 57,
    parameter int W      = 8,
    parameter int THRESH = (N + 1) / 2
) (
    input logic                   clk,
    input logic                   rst_n,
    folded_majority_seq_if.slave  bus
);
    localparam int CW = $clog2(N + 1);
    localparam int C  = (N + W - 1) / W;
    localparam int PW = C * W;                 // padded vector width
    localparam int KW = (C > 1) ? $clog2(C) : 1;
    localparam int EW = CW + 1;                // room for THRESH = N+1

    localparam logic [EW-1:0] THRESH_E = EW'(THRESH);
    localparam logic [KW-1:0] K_LAST   = KW'(C - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] vec_r;      // shifts right by W, chunk k sits at the bottom
    logic [KW-1:0] k_r;
    logic [CW-1:0] count_r;
    logic          y_r;

    logic [CW-1:0] chunk_pop;
    logic [CW-1:0] count_nxt;
    logic          reach;
    logic          finish;

    // one W-bit popcount slice, reused every ACCUM cycle
    always_comb begin
        chunk_pop = '0;
        for (int i = 0; i < W; i++)
            chunk_pop = chunk_pop + CW'(vec_r[i]);
        count_nxt = count_r + chunk_pop;
        reach     = {1'b0, count_nxt} >= THRESH_E;
    end

`ifdef FOLDMAJ_EARLY_EXIT_EN
    logic [EW-1:0] rem;

    always_comb begin
        int consumed;
        consumed = (int'(k_r) + 1) * W;
        if (consumed > N)
            consumed = N;
        rem = EW'(N - consumed);
        // count'+rem <= N, so the sum cannot overflow EW bits
        finish = (k_r == K_LAST) || reach ||
                 (({1'b0, count_nxt} + rem) < THRESH_E);
    end
`else
    always_comb begin
        finish = (k_r == K_LAST);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = ACCUM;
            ACCUM:   if (finish)        state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_r   <= '0;
            k_r     <= '0;
            count_r <= '0;
            y_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    vec_r   <= PW'(bus.in_data);   // zero-pads the last chunk
                    k_r     <= '0;
                    count_r <= '0;
                    y_r     <= 1'b0;
                end
                ACCUM: begin
                    vec_r   <= vec_r >> W;
                    k_r     <= k_r + KW'(1);
                    count_r <= count_nxt;
                    if (finish)
                        y_r <= reach;
                end
                default: ;   // DONE holds results until out_ready
            endcase
        end
    end

    // all outputs come from state or registers only
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.y         = y_r;
    assign bus.count     = count_r;
endmodule

// File: tb/tb_folded_majority_seq.sv
// tb_folded_majority_seq
//   Scoreboard bench: the driver pushes the model's expected result for every
//   accepted vector; an independent monitor pops and compares on each
//   out_valid rise and checks stability/handshake while the result is held.
module tb_folded_majority_seq;
    localparam int N  = 57;
    localparam int W  = 8;
    localparam int TH = 29;
    localparam int C  = (N + W - 1) / W;

    typedef struct {
        logic y;
        int   cnt;
        int   lat;
        int   acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    folded_majority_seq_if #(.N(N)) bus();

    folded_majority_seq #(.N(N), .W(W), .THRESH(TH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // reference: popcount threshold, chunk-by-chunk only to find the exit point
    function automatic exp_t model(input logic [N-1:0] v);
        exp_t e;
        logic [C*W-1:0] p;
        int s, rem;
        p = '0;
        p[N-1:0] = v;
        e.acc = 0;
`ifdef FOLDMAJ_EARLY_EXIT_EN
        s = 0;
        e.lat = C;
        e.y = 1'b0;
        for (int j = 0; j < C; j++) begin
            s += $countones(p[j*W +: W]);
            rem = N - (((j + 1) * W > N) ? N : (j + 1) * W);
            if (s >= TH) begin
                e.y = 1'b1; e.lat = j + 1; break;
            end else if (s + rem < TH || j == C - 1) begin
                e.y = 1'b0; e.lat = j + 1; break;
            end
        end
        e.cnt = s;
`else
        s = $countones(v);
        e.cnt = s;
        e.y = (s >= TH);
        e.lat = C;
`endif
        return e;
    endfunction

    // monitor
    initial begin
        logic prev_ov, rel;
        exp_t cur;
        prev_ov = 1'b0;
        rel = 1'b0;
        cur = '{1'b0, 0, 0, 0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ov = 1'b0;
                rel = 1'b0;
                continue;
            end
            if (rel) begin
                chk("release_out_valid", 32'(bus.out_valid), 32'd0);
                chk("release_in_ready", 32'(bus.in_ready), 32'd1);
            end
            if (bus.out_valid && !prev_ov) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    cur = q.pop_front();
                    chk("y", 32'(bus.y), 32'(cur.y));
                    chk("count", 32'(bus.count), cur.cnt);
                    chk("latency", cyc - cur.acc, cur.lat);
                end
            end else if (bus.out_valid) begin
                chk("hold_y", 32'(bus.y), 32'(cur.y));
                chk("hold_count", 32'(bus.count), cur.cnt);
                chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
            end
            rel = bus.out_valid && bus.out_ready;
            prev_ov = bus.out_valid;
        end
    end

    task automatic send(input logic [N-1:0] v, input int hold, input bit pulse);
        exp_t e;
        int t;
        bus.in_data = v;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        e = model(v);
        e.acc = cyc;
        q.push_back(e);
        bus.in_valid = 1'b0;
        t = 0;
        while (!bus.out_valid && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!bus.out_valid) begin
            chk("timeout_out_valid", 32'd0, 32'd1);
            return;
        end
        for (int h = 0; h < hold; h++) begin
            if (pulse) begin
                bus.in_valid = 1'b1;
                bus.in_data = ~v;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({nm, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({nm, "_y"}, 32'(bus.y), 32'd0);
        chk({nm, "_count"}, 32'(bus.count), 32'd0);
    endtask

    function automatic logic [N-1:0] ones(input int n);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'b1;
        return v;
    endfunction

    initial begin
        logic [N-1:0] v;
        int t;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_reset_vals("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        send('0, 0, 1'b0);
        send(ones(29), 0, 1'b0);
        send(ones(28), 0, 1'b0);
        send(ones(N), 5, 1'b1);          // backpressure with in_valid pulses
        send(ones(30), 2, 1'b0);

        for (int i = 0; i < 30; i++) begin
            v = N'({$urandom(), $urandom()});
            case (i % 3)
                0: v = v & N'({$urandom(), $urandom()});
                1: v = v | N'({$urandom(), $urandom()});
                default: ;
            endcase
            send(v, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // asynchronous reset in the middle of ACCUM
        bus.in_data = N'({$urandom(), $urandom()});
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async_reset");
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        send(ones(30), 0, 1'b0);

        t = 0;
        while (q.size() != 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        chk("scoreboard_drained", q.size(), 32'd0);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end
endmodule
